// File: rtl/freq_measure_mc.sv
`timescale 1ns/1ps
// freq_measure_mc -- multi-channel equal-precision frequency meter.
//
// Every channel runs its own actual gate aligned to its own rising edges,
// counting whole test periods (Nx) and sys_clk cycles (Ns). After the soft
// gate and the closing wait, one shared restoring divider computes
// freq = FSTD*Nx/Ns for each channel in turn. Results are published together
// with a one-cycle done pulse.
//
// Ports:
//   sys_clk     - single clock
//   sys_rst_n   - asynchronous active-low reset
//   test_sig    - asynchronous test inputs, one per channel
//   start       - one-cycle round request, honoured in IDLE only (CONT=0)
//   busy        - high from start acceptance until the cycle after done
//   done        - one-cycle pulse when freq_data/freq_valid update
//   freq_data   - results in Hz, channel k at [k*FREQ_W +: FREQ_W]
//   freq_valid  - per-channel flag, 1 = last round produced a measurement

// Per-channel front end: synchronizer, edge detect, actual gate and counters.
//   sig       - raw asynchronous test input
//   clr       - clears counters and gate flags (round start)
//   soft_gate - shared soft gate
//   active    - counting enabled (soft gate or closing wait)
//   nx, ns    - whole test periods / reference cycles inside the actual gate
//   opened    - actual gate has opened this round
//   closed    - actual gate has closed this round
//   sat       - a counter hit all-ones
module freq_measure_ch #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig,
   input  logic             clr,
   input  logic             soft_gate,
   input  logic             active,
   output logic [CNT_W-1:0] nx,
   output logic [CNT_W-1:0] ns,
   output logic             opened,
   output logic             closed,
   output logic             sat
);
   logic [2:0] sync;
   logic       rise;
   logic       gate_on;

   // sync[1:0] is the 2-flop synchronizer, sync[2] the edge register
   assign rise    = sync[1] & ~sync[2];
   assign gate_on = opened & ~closed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[1:0], sig};
   end

   // Ns counts every cycle after the opening edge up to and including the
   // closing edge; Nx counts rises in the same span, so Ns = Nx * period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nx     <= '0;
         ns     <= '0;
         opened <= 1'b0;
         closed <= 1'b0;
         sat    <= 1'b0;
      end else if (clr) begin
         nx     <= '0;
         ns     <= '0;
         opened <= 1'b0;
         closed <= 1'b0;
         sat    <= 1'b0;
      end else if (active) begin
         if (gate_on) begin
            if (&ns) sat <= 1'b1;
            else     ns  <= ns + 1'b1;
            if (rise) begin
               if (&nx) sat <= 1'b1;
               else     nx  <= nx + 1'b1;
               // a rise in the first cycle with the soft gate low closes
               if (!soft_gate) closed <= 1'b1;
            end
         end else if (!opened && soft_gate && rise) begin
            opened <= 1'b1;
         end
      end
   end
endmodule

module freq_measure_mc #(
   parameter int CH_NUM   = 4,
   parameter int FSTD     = 50_000_000,
   parameter int GATE_CYC = 62_500_000,
   parameter int TMO_CYC  = 12_500_000,
   parameter int CNT_W    = 32,
   parameter int FREQ_W   = 32,
   parameter int CONT     = 0
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [CH_NUM-1:0]        test_sig,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [CH_NUM*FREQ_W-1:0] freq_data,
   output logic [CH_NUM-1:0]        freq_valid
);
   localparam int NUM_W = CNT_W + 32;
   localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int GC_W  = $clog2(GATE_CYC + 1);
   localparam int TC_W  = $clog2(TMO_CYC + 1);
   localparam int BC_W  = $clog2(NUM_W + 1);

   typedef enum logic [2:0] {IDLE, GATE, WAIT, DIV, DONE} state_t;
   state_t state;

   logic [GC_W-1:0]  gate_cnt;
   logic [TC_W-1:0]  tmo_cnt;
   logic [IDX_W-1:0] ch_idx;
   logic [BC_W-1:0]  bit_cnt;
   logic             div_run;
   logic [NUM_W-1:0] num;
   logic [CNT_W-1:0] rem;

   logic [CH_NUM-1:0][CNT_W-1:0]  nx, ns;
   logic [CH_NUM-1:0]             opened, closed, sat, ch_ok;
   logic [CH_NUM-1:0][FREQ_W-1:0] res_sh, res_nxt;
   logic [CH_NUM-1:0]             vld_sh, vld_nxt;

   logic             enter_gate, soft_gate, active, all_closed;
   logic [NUM_W-1:0] prod, quo;
   logic [CNT_W:0]   rem_sh;
   logic [CNT_W-1:0] rem_nxt, ns_sel;
   logic             q_bit, ovf;
   logic             wr_en, wr_vld, wr_last;
   logic [FREQ_W-1:0] wr_val;

   assign enter_gate = (state == IDLE && (CONT != 0 || start)) ||
                       (state == DONE && CONT != 0);
   assign soft_gate  = (state == GATE);
   assign active     = (state == GATE) || (state == WAIT);

   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      freq_measure_ch #(.CNT_W(CNT_W)) u_ch (
         .clk       (sys_clk),
         .rst_n     (sys_rst_n),
         .sig       (test_sig[k]),
         .clr       (enter_gate),
         .soft_gate (soft_gate),
         .active    (active),
         .nx        (nx[k]),
         .ns        (ns[k]),
         .opened    (opened[k]),
         .closed    (closed[k]),
         .sat       (sat[k])
      );
   end

   // a channel whose gate never opened can no longer open once the soft
   // gate is down, so it does not hold up the wait
   assign all_closed = &(closed | ~opened);
   assign ch_ok      = closed & ~sat;

   // restoring divider step; num shifts out numerator bits and shifts in
   // quotient bits, so after NUM_W steps it holds the quotient
   assign ns_sel  = ns[ch_idx];
   assign prod    = NUM_W'(FSTD) * NUM_W'(nx[ch_idx]);
   assign rem_sh  = {rem, num[NUM_W-1]};
   assign q_bit   = (rem_sh >= {1'b0, ns_sel});
   assign rem_nxt = q_bit ? CNT_W'(rem_sh - {1'b0, ns_sel}) : CNT_W'(rem_sh);
   assign quo     = {num[NUM_W-2:0], q_bit};
   assign ovf     = ((quo >> FREQ_W) != '0);

   always_comb begin
      wr_en  = 1'b0;
      wr_vld = 1'b0;
      wr_val = '0;
      if (state == DIV) begin
         if (!ch_ok[ch_idx]) begin
            wr_en = 1'b1;
         end else if (div_run && bit_cnt == BC_W'(NUM_W - 1)) begin
            wr_en  = 1'b1;
            wr_vld = 1'b1;
            wr_val = ovf ? '1 : quo[FREQ_W-1:0];
         end
      end
      // shadow with the in-flight write merged, so the last channel's
      // result is published in the same edge that enters DONE
      res_nxt = res_sh;
      vld_nxt = vld_sh;
      if (wr_en) begin
         res_nxt[ch_idx] = wr_val;
         vld_nxt[ch_idx] = wr_vld;
      end
   end

   assign wr_last = wr_en && (ch_idx == IDX_W'(CH_NUM - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         freq_data  <= '0;
         freq_valid <= '0;
         res_sh     <= '0;
         vld_sh     <= '0;
         gate_cnt   <= '0;
         tmo_cnt    <= '0;
         ch_idx     <= '0;
         bit_cnt    <= '0;
         div_run    <= 1'b0;
         num        <= '0;
         rem        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (CONT != 0 || start) begin
                  state    <= GATE;
                  busy     <= 1'b1;
                  gate_cnt <= '0;
               end
            end
            GATE: begin
               if (gate_cnt == GC_W'(GATE_CYC - 1)) begin
                  state   <= WAIT;
                  tmo_cnt <= '0;
               end else begin
                  gate_cnt <= gate_cnt + 1'b1;
               end
            end
            WAIT: begin
               if (all_closed || tmo_cnt == TC_W'(TMO_CYC - 1)) begin
                  state   <= DIV;
                  ch_idx  <= '0;
                  div_run <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DIV: begin
               if (div_run) begin
                  num     <= quo;
                  rem     <= rem_nxt;
                  bit_cnt <= bit_cnt + 1'b1;
               end else if (ch_ok[ch_idx]) begin
                  num     <= prod;
                  rem     <= '0;
                  bit_cnt <= '0;
                  div_run <= 1'b1;
               end
               if (wr_en) begin
                  div_run <= 1'b0;
                  res_sh  <= res_nxt;
                  vld_sh  <= vld_nxt;
                  if (wr_last) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     freq_data  <= res_nxt;
                     freq_valid <= vld_nxt;
                  end else begin
                     ch_idx <= ch_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               busy <= (CONT != 0);
               if (CONT != 0) begin
                  state    <= GATE;
                  gate_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
